// File: rtl/coproc_pkg.sv
// coproc_pkg: shared frame geometry, pixel type and window-generator state encoding
package coproc_pkg;
    localparam int PIX_W = 12;
    localparam int IMG_W = 256;
    localparam int IMG_H = 256;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef enum logic [2:0] {IDLE, WAIT_ROW, STREAM, FLUSH, DONE} cwg_state_t;
endpackage

// File: rtl/win_tap_mux.sv
// win_tap_mux: picks pixels col-1, col, col+1 from one packed row, zeroing taps beyond the edges
module win_tap_mux import coproc_pkg::*; (
    input  logic [IMG_W*PIX_W-1:0] row,
    input  logic [7:0]             col,
    output logic [3*PIX_W-1:0]     taps
);
    pixel_t px [IMG_W];
    pixel_t lft;
    pixel_t mid;
    pixel_t rgt;
    for (genvar i = 0; i < IMG_W; i++) begin : g_px
        assign px[i] = row[i*PIX_W +: PIX_W];
    end
    // Neighbour fetch; the first and last columns see zero padding outside the row
    always_comb begin
        lft  = col == '0 ? '0 : px[col - 8'd1];
        mid  = px[col];
        rgt  = col == 8'(IMG_W-1) ? '0 : px[col + 8'd1];
        taps = {rgt, mid, lft};
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: 3-row sliding buffer streaming one zero-padded 3x3 window per pixel
module conv_window_gen #(
    parameter int IMG_H = coproc_pkg::IMG_H
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       row_vld,
    input  logic [coproc_pkg::IMG_W*coproc_pkg::PIX_W-1:0] row_in,
    output logic                                       row_rdy,
    output logic                                       win_vld,
    input  logic                                       win_rdy,
    output logic [9*coproc_pkg::PIX_W-1:0]             win_data,
    output logic [7:0]                                 win_col,
    output logic [7:0]                                 win_row,
    output logic                                       frame_done
);
    import coproc_pkg::*;
    localparam int RW   = IMG_W*PIX_W;
    localparam int RC_W = $clog2(IMG_H+1);
    cwg_state_t state;
    cwg_state_t nxt;
    logic [RW-1:0] r0;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [RC_W-1:0] rc;
    logic flushed;
    logic accept;
    logic hs;
    logic last;
    logic [3*PIX_W-1:0] t0;
    logic [3*PIX_W-1:0] t1;
    logic [3*PIX_W-1:0] t2;
    assign row_rdy    = state == WAIT_ROW;
    assign win_vld    = state == STREAM;
    assign frame_done = state == DONE;
    assign accept     = row_vld && row_rdy && !start;
    assign hs         = win_vld && win_rdy && !start;
    assign last       = hs && win_col == 8'(IMG_W-1);
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end
    // Next state; start restarts the frame from any state and wins over handshakes
    always_comb begin
        nxt = state;
        case (state)
            WAIT_ROW: nxt = accept && rc != '0 ? STREAM : WAIT_ROW;
            STREAM:   nxt = !last ? STREAM : rc < RC_W'(IMG_H) ? WAIT_ROW : flushed ? DONE : FLUSH;
            FLUSH:    nxt = STREAM;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (start)
            nxt = WAIT_ROW;
    end
    // Row buffer shift, row count and window position tracking
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            rc      <= '0;
            flushed <= 1'b0;
            win_col <= '0;
            win_row <= '0;
        end else begin
            if (accept) begin
                r0 <= r1;
                r1 <= r2;
                r2 <= row_in;
                rc <= rc + RC_W'(1);
            end
            if (state == FLUSH) begin
                r0      <= r1;
                r1      <= r2;
                r2      <= '0;
                flushed <= 1'b1;
            end
            if (hs)
                win_col <= win_col + 8'd1;
            if (last)
                win_row <= win_row + 8'd1;
            if ((accept && rc != '0) || state == FLUSH)
                win_col <= '0;
        end
    end
    win_tap_mux u_top (.row(r0), .col(win_col), .taps(t0));
    win_tap_mux u_mid (.row(r1), .col(win_col), .taps(t1));
    win_tap_mux u_bot (.row(r2), .col(win_col), .taps(t2));
    assign win_data = {t2, t1, t0};
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed frame runs with stalls, mid-frame restart and mid-frame reset
module tb_conv_window_gen;
    localparam int H = 4;
    localparam logic [107:0] D00 = {12'h101, 12'h100, 12'h000, 12'h001, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    localparam logic [107:0] D102 = {12'h30B, 12'h30A, 12'h309, 12'h20B, 12'h20A, 12'h209, 12'h10B, 12'h10A, 12'h109};
    localparam logic [107:0] D2553 = {12'h000, 12'h000, 12'h000, 12'h000, 12'h3FF, 12'h3FE, 12'h000, 12'h2FF, 12'h2FE};
    logic clk = 0;
    logic rst_n, start, row_vld, win_rdy;
    logic [3071:0] row_in;
    logic row_rdy, win_vld, frame_done;
    logic [107:0] win_data;
    logic [7:0] win_col, win_row;
    int total = 0;
    int bad = 0;
    conv_window_gen #(.IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_vld(row_vld), .row_in(row_in),
        .row_rdy(row_rdy), .win_vld(win_vld), .win_rdy(win_rdy), .win_data(win_data),
        .win_col(win_col), .win_row(win_row), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [3071:0] mk_row(input int y);
        logic [3071:0] r = '0;
        for (int x = 0; x < 256; x++) r[x*12 +: 12] = 12'((y << 8) | x);
        return r;
    endfunction
    function automatic logic [107:0] exp_win(input int x, input int y);
        logic [107:0] w = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                int yy = y + dy - 1;
                int xx = x + dx - 1;
                if (yy >= 0 && yy < H && xx >= 0 && xx < 256) w[(dy*3+dx)*12 +: 12] = 12'((yy << 8) | xx);
            end
        return w;
    endfunction
    // kind: 0 run to completion, 1 restart with start at (sx,sy), 2 reset at (sx,sy)
    task automatic run_frame(input bit do_start, input bit rnd, input int kind, input int sx, input int sy);
        int nrow = 0;
        int nwin = 0;
        int cyc = 0;
        bit row1 = 0;
        bit last_hs = 0;
        bit stalled = 0;
        bit finished = 0;
        bit hs, acc;
        if (do_start) begin
            start = 1;
            @(negedge clk);
            start = 0;
        end
        while (!finished && cyc < 6000) begin
            if (nrow < 2) chk("prime_no_window", win_vld, 0);
            if (row1) chk("first_window_latency", win_vld, 1);
            if (stalled) chk("stall_hold_vld", win_vld, 1);
            chk("frame_done", frame_done, last_hs);
            if (last_hs) finished = 1;
            if (win_vld) begin
                chk("row_rdy_in_stream", row_rdy, 0);
                chk("win_col", win_col, nwin % 256);
                chk("win_row", win_row, nwin / 256);
                chk("win_data", win_data, exp_win(nwin % 256, nwin / 256));
                if (nwin == 0) chk("win_0_0", win_data, D00);
                if (nwin == 2*256 + 10) chk("win_10_2", win_data, D102);
                if (nwin == 3*256 + 255) chk("win_255_3", win_data, D2553);
            end
            win_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            row_vld = nrow < H;
            row_in = mk_row(nrow);
            if (kind != 0 && win_vld && nwin == sy*256 + sx) begin
                row_vld = 0;
                if (kind == 1) begin
                    start = 1;
                    win_rdy = 1;
                    @(negedge clk);
                    start = 0;
                    chk("restart_vld_drop", win_vld, 0);
                    chk("restart_row_rdy", row_rdy, 1);
                    chk("restart_col", win_col, 0);
                    chk("restart_row", win_row, 0);
                    chk("restart_no_done", frame_done, 0);
                end else begin
                    rst_n = 0;
                    @(negedge clk);
                    rst_n = 1;
                    chk("rst_row_rdy", row_rdy, 0);
                    chk("rst_win_vld", win_vld, 0);
                    chk("rst_win_data", win_data, 0);
                    chk("rst_win_col", win_col, 0);
                    chk("rst_win_row", win_row, 0);
                    chk("rst_frame_done", frame_done, 0);
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("rst_idle_no_done", frame_done, 0);
                        chk("rst_idle_no_vld", win_vld, 0);
                    end
                end
                return;
            end
            hs = win_vld && win_rdy;
            acc = row_rdy && row_vld;
            row1 = acc && nrow == 1;
            stalled = win_vld && !win_rdy;
            last_hs = hs && nwin == 256*H - 1;
            if (hs) nwin++;
            if (acc) nrow++;
            @(negedge clk);
            cyc++;
        end
        chk("frame_completed", finished, 1);
        chk("window_count", nwin, 256*H);
        chk("idle_done_low", frame_done, 0);
        chk("idle_vld_low", win_vld, 0);
        chk("idle_rdy_low", row_rdy, 0);
    endtask
    initial begin
        rst_n = 0;
        start = 0;
        row_vld = 0;
        win_rdy = 0;
        row_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_row_rdy", row_rdy, 0);
        chk("reset_win_vld", win_vld, 0);
        chk("reset_win_data", win_data, 0);
        chk("reset_win_col", win_col, 0);
        chk("reset_win_row", win_row, 0);
        chk("reset_frame_done", frame_done, 0);
        rst_n = 1;
        @(negedge clk);
        run_frame(1, 0, 0, 0, 0);
        run_frame(1, 1, 0, 0, 0);
        run_frame(1, 0, 1, 100, 1);
        run_frame(0, 0, 0, 0, 0);
        run_frame(1, 1, 2, 50, 2);
        run_frame(1, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
